// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: bundles the two requester channels and the multu-side
// signals of mult_arbiter.
//   slave  : arbiter view (takes requests/m_out/m_done, drives ready/resp/m_*)
//   master : environment view (requesters plus multu model)
// Ports: none besides the WIDTH parameter; clk/reset stay on the module.
interface mult_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             resp0_valid;
  logic [WIDTH-1:0] resp0_data;
  logic             resp0_err;
  logic             resp0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             resp1_valid;
  logic [WIDTH-1:0] resp1_data;
  logic             resp1_err;
  logic             resp1_ready;

  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic             m_doMult;
  logic             m_reset;
  logic [WIDTH-1:0] m_out;
  logic             m_done;

  modport slave (
    input  req0_valid, req0_a, req0_b, resp0_ready,
    input  req1_valid, req1_a, req1_b, resp1_ready,
    input  m_out, m_done,
    output req0_ready, resp0_valid, resp0_data, resp0_err,
    output req1_ready, resp1_valid, resp1_data, resp1_err,
    output m_a, m_b, m_doMult, m_reset
  );

  modport master (
    output req0_valid, req0_a, req0_b, resp0_ready,
    output req1_valid, req1_a, req1_b, resp1_ready,
    output m_out, m_done,
    input  req0_ready, resp0_valid, resp0_data, resp0_err,
    input  req1_ready, resp1_valid, resp1_data, resp1_err,
    input  m_a, m_b, m_doMult, m_reset
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one multu multiplier between two requesters.
// Round-robin grant in IDLE, operands latched to m_a/m_b, one-cycle m_doMult,
// wait for m_done (or watchdog abort), then return the product to the winner
// over a valid/ready handshake.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   bus    - mult_arbiter_if.slave: req0/1 valid/a/b/ready, resp0/1
//            valid/data/err/ready, multu m_a/m_b/m_doMult/m_reset/m_out/m_done
module mult_arbiter #(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 300
) (
  input  logic          clk,
  input  logic          reset,
  mult_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             acc0, acc1;
  logic             wdog;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    err_d        = err_q;
    acc0         = 1'b0;
    acc1         = 1'b0;
    wdog         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // Tie goes to the requester that did not win last time.
          if (bus.req0_valid && bus.req1_valid) grant_d = ~last_grant_q;
          else                                  grant_d = bus.req1_valid;
          acc0         = ~grant_d;
          acc1         = grant_d;
          last_grant_d = grant_d;
          a_d          = grant_d ? bus.req1_a : bus.req0_a;
          b_d          = grant_d ? bus.req1_b : bus.req0_b;
          state_d      = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // m_done has priority over a watchdog expiry in the same cycle.
        if (bus.m_done) begin
          data_d  = bus.m_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          wdog    = 1'b1;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (grant_q ? bus.resp1_ready : bus.resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  // Accept is combinational from IDLE; blocked while reset is sampled so no
  // requester sees a handshake that the reset is about to discard.
  assign bus.req0_ready  = acc0 & ~reset;
  assign bus.req1_ready  = acc1 & ~reset;

  assign bus.resp0_valid = (state_q == RESP) & ~grant_q;
  assign bus.resp1_valid = (state_q == RESP) &  grant_q;
  assign bus.resp0_data  = bus.resp0_valid ? data_q : '0;
  assign bus.resp1_data  = bus.resp1_valid ? data_q : '0;
  assign bus.resp0_err   = bus.resp0_valid & err_q;
  assign bus.resp1_err   = bus.resp1_valid & err_q;

  assign bus.m_a         = a_q;
  assign bus.m_b         = b_q;
  assign bus.m_doMult    = (state_q == START) & ~reset;
  assign bus.m_reset     = reset | wdog;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  localparam int W  = 32;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_arbiter_if #(.WIDTH(W)) bus ();

  mult_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit last_g = 1'b1;  // reference model: last granted requester

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag, input logic exp_mreset);
    chk1({tag, "_ready0"},  bus.req0_ready,  1'b0);
    chk1({tag, "_ready1"},  bus.req1_ready,  1'b0);
    chk1({tag, "_rvalid0"}, bus.resp0_valid, 1'b0);
    chk1({tag, "_rvalid1"}, bus.resp1_valid, 1'b0);
    chkw({tag, "_rdata0"},  bus.resp0_data,  '0);
    chkw({tag, "_rdata1"},  bus.resp1_data,  '0);
    chk1({tag, "_rerr0"},   bus.resp0_err,   1'b0);
    chk1({tag, "_rerr1"},   bus.resp1_err,   1'b0);
    chk1({tag, "_domult"},  bus.m_doMult,    1'b0);
    chk1({tag, "_mreset"},  bus.m_reset,     exp_mreset);
    chkw({tag, "_ma"},      bus.m_a,         '0);
    chkw({tag, "_mb"},      bus.m_b,         '0);
  endtask

  // One full transaction. Valids/operands are held for the whole call.
  // delay: BUSY cycle on which m_done is raised (<1 or >TO means never).
  // hold : cycles resp_valid is seen before the winner raises resp_ready.
  task automatic transact(input string tag, input bit v0, input bit v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int delay, input int hold);
    bit               g, tmo;
    int               n;
    logic [W-1:0]     ea, eb, prod, edata;
    logic [2*W-1:0]   full;
    g      = (v0 && v1) ? !last_g : v1;
    last_g = g;
    ea     = g ? a1 : a0;
    eb     = g ? b1 : b0;
    full   = (2*W)'(ea) * (2*W)'(eb);
    prod   = full[W-1:0];
    tmo    = (delay < 1) || (delay > TO);
    n      = tmo ? TO : delay;
    edata  = tmo ? '0 : prod;

    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0; bus.m_done = 1'b0;
    #1;
    chk1({tag, "_acc_ready0"}, bus.req0_ready, !g);
    chk1({tag, "_acc_ready1"}, bus.req1_ready, g);
    chk1({tag, "_acc_domult"}, bus.m_doMult, 1'b0);

    tick(); #1;  // START
    chk1({tag, "_start_domult"}, bus.m_doMult, 1'b1);
    chkw({tag, "_start_ma"}, bus.m_a, ea);
    chkw({tag, "_start_mb"}, bus.m_b, eb);
    chk1({tag, "_start_ready0"}, bus.req0_ready, 1'b0);
    chk1({tag, "_start_ready1"}, bus.req1_ready, 1'b0);

    for (int k = 1; k <= n; k++) begin  // BUSY
      tick();
      bus.m_out = $urandom;
      if (k == n && !tmo) begin
        bus.m_done = 1'b1;
        bus.m_out  = prod;
      end
      #1;
      chk1({tag, "_busy_domult"}, bus.m_doMult, 1'b0);
      chk1({tag, "_busy_mreset"}, bus.m_reset, (k == n) && tmo);
      chkw({tag, "_busy_ma"}, bus.m_a, ea);
      chkw({tag, "_busy_mb"}, bus.m_b, eb);
      chk1({tag, "_busy_ready"}, bus.req0_ready | bus.req1_ready, 1'b0);
      chk1({tag, "_busy_rvalid"}, bus.resp0_valid | bus.resp1_valid, 1'b0);
    end

    tick();  // RESP
    bus.m_done = 1'b0;
    bus.m_out  = $urandom;
    if (g) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;  // loser's ready must not count
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        if (g) bus.resp1_ready = 1'b1; else bus.resp0_ready = 1'b1;
      end
      #1;
      chk1({tag, "_resp_valid_w"}, g ? bus.resp1_valid : bus.resp0_valid, 1'b1);
      chk1({tag, "_resp_valid_l"}, g ? bus.resp0_valid : bus.resp1_valid, 1'b0);
      chkw({tag, "_resp_data"}, g ? bus.resp1_data : bus.resp0_data, edata);
      chk1({tag, "_resp_err"}, g ? bus.resp1_err : bus.resp0_err, tmo);
      chk1({tag, "_resp_domult"}, bus.m_doMult, 1'b0);
      chk1({tag, "_resp_mreset"}, bus.m_reset, 1'b0);
      chk1({tag, "_resp_ready"}, bus.req0_ready | bus.req1_ready, 1'b0);
      if (h < hold) tick();
    end

    tick();  // back in IDLE
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    #1;
    chk1({tag, "_end_rvalid0"}, bus.resp0_valid, 1'b0);
    chk1({tag, "_end_rvalid1"}, bus.resp1_valid, 1'b0);
  endtask

  initial begin
    logic [1:0] v;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.resp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.resp1_ready = 1'b0;
    bus.m_out = '0; bus.m_done = 1'b0;
    reset = 1'b1;
    tick(); tick(); #1;
    check_quiet("rst", 1'b1);
    reset = 1'b0;
    #1;
    check_quiet("rst_rel", 1'b0);

    // single requester, done after 64 cycles
    transact("t1", 1'b1, 1'b0, 32'd1, 32'd5, '0, '0, 64, 0);

    // fresh reset, both requesters always valid: grants 0,1,0,1
    reset = 1'b1; tick(); reset = 1'b0; last_g = 1'b1;
    for (int i = 0; i < 4; i++)
      transact("t2", 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom,
               $urandom_range(1, 12), $urandom_range(0, 2));

    // response held back 10 cycles
    transact("t3", 1'b0, 1'b1, '0, '0, 32'd7, 32'd6, 5, 10);

    // multiplier hangs: watchdog abort
    transact("t4", 1'b1, 1'b0, $urandom, $urandom, '0, '0, -1, 2);

    // m_done on the very cycle the watchdog would fire
    transact("t6", 1'b0, 1'b1, '0, '0, $urandom, $urandom, TO, 1);

    // done one cycle before the watchdog limit
    transact("t6b", 1'b1, 1'b0, $urandom, $urandom, '0, '0, TO - 1, 0);

    // reset in the middle of BUSY, followed by a stray m_done
    bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req1_valid = 1'b0;
    #1;
    chk1("t5_acc_ready0", bus.req0_ready, 1'b1);
    tick(); bus.req0_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk1("t5_rst_mreset", bus.m_reset, 1'b1);
    tick();
    reset = 1'b0;
    bus.m_done = 1'b1;
    bus.m_out  = 32'h1234;
    #1;
    check_quiet("t5_after", 1'b0);
    last_g = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.m_done = 1'b0;
      #1;
      chk1("t5_no_resp0", bus.resp0_valid, 1'b0);
      chk1("t5_no_resp1", bus.resp1_valid, 1'b0);
      chk1("t5_no_domult", bus.m_doMult, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      v = 2'($urandom_range(1, 3));
      transact("rnd", v[0], v[1], $urandom, $urandom, $urandom, $urandom,
               $urandom_range(1, 20), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
